slow_clk_monitor: RTL and testbench

Receive-side companion to the LCD clock divider. Takes the divided slow clock (nominally 100 Hz) back into the 48 MHz domain, synchronizes it, and emits single-cycle rise/fall strobes for LCD sequencing logic. Measures the period and high time in 48 MHz cycles and flags loss of the slow clock. It sits between the divider output and any 48 MHz-domain consumer of slow ticks.

---
 rtl/slow_clk_monitor.sv | 123 ++++++++++++
 tb/tb_slow_clk_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
// Slow-clock receive monitor: synchronizes a divided clock into the 48 MHz domain,
// emits rise/fall strobes, measures period and high time, and flags loss of clock.
module slow_clk_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned TIMEOUT     = 1200000
) (
    input  logic             clk_48Mhz,
    input  logic             rst,
    input  logic             slow_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             clk_lost
);

    localparam int unsigned     SYNC_MSB  = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             armed_q, armed_d;
    logic             h_armed_q, h_armed_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             fall_pulse_q, fall_pulse_d;
    logic             meas_valid_q, meas_valid_d;
    logic             clk_lost_q, clk_lost_d;

    // Synchronizer chain, history flop and registered edge detect
    always_ff @(posedge clk_48Mhz) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prev_q <= sync_q[SYNC_MSB];
            rise_q <= sync_q[SYNC_MSB] & ~prev_q;
            fall_q <= ~sync_q[SYNC_MSB] & prev_q;
        end
    end

    // Measurement next-state: counter restarts on rise and saturates at all-ones
    always_comb begin
        cnt_d        = cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        armed_d      = armed_q;
        h_armed_d    = h_armed_q;
        rise_pulse_d = rise_q;
        fall_pulse_d = fall_q;
        meas_valid_d = 1'b0;
        clk_lost_d   = clk_lost_q;

        if (rise_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (rise_q) begin
            armed_d   = 1'b1;
            h_armed_d = 1'b1;
            if (armed_q) begin
                period_d     = cnt_q;
                meas_valid_d = 1'b1;
            end
        end else if (fall_q) begin
            h_armed_d = 1'b0;
            if (h_armed_q) begin
                high_d = cnt_q;
            end
        end

        if (rise_q) begin
            clk_lost_d = 1'b0;
        end else if (cnt_d >= TIMEOUT_C) begin
            clk_lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk_48Mhz) begin
        if (rst) begin
            cnt_q        <= '0;
            period_q     <= '0;
            high_q       <= '0;
            armed_q      <= 1'b0;
            h_armed_q    <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            meas_valid_q <= 1'b0;
            clk_lost_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            armed_q      <= armed_d;
            h_armed_q    <= h_armed_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            meas_valid_q <= meas_valid_d;
            clk_lost_q   <= clk_lost_d;
        end
    end

    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_valid_q;
    assign clk_lost   = clk_lost_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor: latency, asymmetric duty, loss of clock,
// counter saturation and mid-operation reset, with hand-computed expectations.
module tb_slow_clk_monitor;

    localparam int unsigned SYNC_STAGES = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT     = 100;

    logic             clk_48Mhz = 1'b0;
    logic             rst       = 1'b1;
    logic             slow_clk  = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             clk_lost;

    int n_checks = 0;
    int n_fail   = 0;
    bit inv_on   = 1'b0;

    slow_clk_monitor #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_48Mhz (clk_48Mhz),
        .rst       (rst),
        .slow_clk  (slow_clk),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .clk_lost  (clk_lost)
    );

    always #5 clk_48Mhz = ~clk_48Mhz;

    typedef struct {
        string       name;
        logic        rst;
        logic        sc;
        int unsigned n;
        logic        rise;
        logic        fall;
        logic        mv;
        logic        lost;
        int unsigned per;
        int unsigned hi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic sc, int unsigned n,
                                logic ri, logic fa, logic mv, logic lo,
                                int unsigned per, int unsigned hi);
        vec_t v;
        v.name = name; v.rst = r; v.sc = sc; v.n = n;
        v.rise = ri; v.fall = fa; v.mv = mv; v.lost = lo;
        v.per = per; v.hi = hi;
        return v;
    endfunction

    // Apply inputs for n edges; outputs are then sampled 1 time unit after the last edge
    task automatic drive(input logic r, input logic sc, input int unsigned n);
        repeat (n) begin
            @(negedge clk_48Mhz);
            rst      = r;
            slow_clk = sc;
            @(posedge clk_48Mhz);
            #1;
        end
    endtask

    task automatic check(input string name, input logic ri, input logic fa, input logic mv,
                         input logic lo, input int unsigned per, input int unsigned hi);
        n_checks++;
        if (rise_pulse !== ri || fall_pulse !== fa || meas_valid !== mv || clk_lost !== lo ||
            period !== CNT_W'(per) || high_time !== CNT_W'(hi)) begin
            n_fail++;
            $display("FAIL %s: got rise=%0b fall=%0b mv=%0b lost=%0b period=%0d high=%0d, expected rise=%0b fall=%0b mv=%0b lost=%0b period=%0d high=%0d",
                     name, rise_pulse, fall_pulse, meas_valid, clk_lost, period, high_time,
                     ri, fa, mv, lo, per, hi);
        end
    endtask

    // Strobes are mutually exclusive and meas_valid only accompanies a rise
    always @(negedge clk_48Mhz) begin
        if (inv_on) begin
            n_checks++;
            if ((rise_pulse && fall_pulse) || (meas_valid && !rise_pulse)) begin
                n_fail++;
                $display("FAIL strobe_excl: rise=%0b fall=%0b mv=%0b, expected no overlap",
                         rise_pulse, fall_pulse, meas_valid);
            end
        end
    end

    initial begin
        //                name               rst  sc   n    rise fall mv   lost per  hi
        vecs.push_back(mk("rst_a",           1,   1,   1,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("rst_b",           1,   0,   1,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("rst_c",           1,   1,   1,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("post_rst",        0,   1,   1,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("pre_latency",     0,   1,   3,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("first_rise",      0,   1,   1,   1,   0,   0,   0,   0,   0));
        vecs.push_back(mk("rise_single",     0,   1,   1,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("hold_high",       0,   1,   4,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("pre_fall",        0,   0,   4,   0,   0,   0,   0,   0,   0));
        vecs.push_back(mk("first_fall",      0,   0,   1,   0,   1,   0,   0,   0,   10));
        vecs.push_back(mk("fall_single",     0,   0,   1,   0,   0,   0,   0,   0,   10));
        vecs.push_back(mk("hold_low",        0,   0,   24,  0,   0,   0,   0,   0,   10));
        vecs.push_back(mk("pre_rise2",       0,   1,   4,   0,   0,   0,   0,   0,   10));
        vecs.push_back(mk("second_rise",     0,   1,   1,   1,   0,   1,   0,   40,  10));
        vecs.push_back(mk("rise2_single",    0,   1,   1,   0,   0,   0,   0,   40,  10));
        vecs.push_back(mk("hold_high2",      0,   1,   4,   0,   0,   0,   0,   40,  10));
        vecs.push_back(mk("second_fall",     0,   0,   5,   0,   1,   0,   0,   40,  10));
        vecs.push_back(mk("hold_low2",       0,   0,   25,  0,   0,   0,   0,   40,  10));
        vecs.push_back(mk("third_rise",      0,   1,   5,   1,   0,   1,   0,   40,  10));
        vecs.push_back(mk("pre_timeout",     0,   1,   98,  0,   0,   0,   0,   40,  10));
        vecs.push_back(mk("timeout",         0,   1,   1,   0,   0,   0,   1,   40,  10));
        vecs.push_back(mk("stop_low",        0,   0,   4,   0,   0,   0,   1,   40,  10));
        vecs.push_back(mk("lost_fall",       0,   0,   1,   0,   1,   0,   1,   40,  104));
        vecs.push_back(mk("lost_low",        0,   0,   5,   0,   0,   0,   1,   40,  104));
        vecs.push_back(mk("restart_pre",     0,   1,   3,   0,   0,   0,   1,   40,  104));
        vecs.push_back(mk("restart_m1",      0,   1,   1,   0,   0,   0,   1,   40,  104));
        vecs.push_back(mk("restart_rise",    0,   1,   1,   1,   0,   1,   0,   114, 104));
        vecs.push_back(mk("sat_pre_to",      0,   1,   98,  0,   0,   0,   0,   114, 104));
        vecs.push_back(mk("sat_to",          0,   1,   1,   0,   0,   0,   1,   114, 104));
        vecs.push_back(mk("sat_high",        0,   1,   96,  0,   0,   0,   1,   114, 104));
        vecs.push_back(mk("sat_pre_fall",    0,   0,   4,   0,   0,   0,   1,   114, 104));
        vecs.push_back(mk("sat_fall",        0,   0,   1,   0,   1,   0,   1,   114, 200));
        vecs.push_back(mk("sat_low",         0,   0,   195, 0,   0,   0,   1,   114, 200));
        vecs.push_back(mk("sat_pre_rise",    0,   1,   4,   0,   0,   0,   1,   114, 200));
        vecs.push_back(mk("sat_rise",        0,   1,   1,   1,   0,   1,   0,   255, 200));

        inv_on = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sc, vecs[i].n);
            check(vecs[i].name, vecs[i].rise, vecs[i].fall, vecs[i].mv, vecs[i].lost,
                  vecs[i].per, vecs[i].hi);
        end

        // Mid-operation reset 50 cycles after a rise, slow_clk held high through it
        drive(0, 1, 49);
        check("mid_pre_rst",   0, 0, 0, 0, 255, 200);
        drive(1, 1, 1);
        check("mid_rst",       0, 0, 0, 0, 0, 0);
        drive(0, 1, 1);
        check("mid_post_rst",  0, 0, 0, 0, 0, 0);
        drive(0, 1, 3);
        check("mid_no_stale",  0, 0, 0, 0, 0, 0);
        drive(0, 1, 1);
        check("mid_first_rise", 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1);
        check("mid_rise_single", 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4);
        drive(0, 0, 5);
        check("mid_fall",      0, 1, 0, 0, 0, 10);
        drive(0, 0, 25);
        drive(0, 1, 4);
        check("mid_pre_rise",  0, 0, 0, 0, 0, 10);
        drive(0, 1, 1);
        check("mid_second_rise", 1, 0, 1, 0, 40, 10);

        // Slow clock never starts after reset: counter runs from 0 to TIMEOUT
        drive(1, 0, 1);
        check("dead_rst",      0, 0, 0, 0, 0, 0);
        drive(0, 0, 99);
        check("dead_pre_to",   0, 0, 0, 0, 0, 0);
        drive(0, 0, 1);
        check("dead_to",       0, 0, 0, 1, 0, 0);

        inv_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
